// File: rtl/sense_amp_seq.sv
// Sense-amplifier read sequencer: precharge, develop, sense and hold.
// Optional per-column margin checking is compiled in with SA_MARGIN_CHK_EN.
module sense_amp_seq #(
    parameter int  ROWS    = 16,
    parameter int  COLS    = 8,
    parameter int  PRE_CYC = 2,
    parameter int  DEV_CYC = 3,
    parameter real VTH     = 0.8,
    parameter real VDD     = 1.5,
    parameter real VSS     = 0.0,
    parameter real VMARGIN = 0.2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req,
    output logic            rd_busy,
    input  real             row_rd [ROWS],
    input  real             bl_rd  [ROWS][COLS],
    input  real             blb_rd [ROWS][COLS],
    output logic            pre_en,
    output logic            sa_en,
    output logic [COLS-1:0] dout,
    output real             preout [COLS],
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            err_row,
    output logic            err_bit,
    output logic            err_margin
);

    typedef enum logic [2:0] {
        IDLE,
        PRECH,
        DEVELOP,
        SENSE,
        DONE
    } state_t;

    state_t          state;
    logic [3:0]      cnt;

    int              sel_count;
    logic [COLS-1:0] row_bits;
    logic [COLS-1:0] row_amb;
    logic            one_hot;
    logic [COLS-1:0] cap_dout;
    logic            cap_err_row;
    logic            cap_err_bit;

    assign rd_busy = (state != IDLE);

    // Decode every row in parallel; the per-column result only matters when
    // exactly one row crosses the threshold, so later rows may overwrite.
    always_comb begin
        sel_count = 0;
        row_bits  = '0;
        row_amb   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_rd[r] >= VTH) begin
                sel_count = sel_count + 1;
                for (int c = 0; c < COLS; c++) begin
                    if (bl_rd[r][c] >= VTH && blb_rd[r][c] < VTH) begin
                        row_bits[c] = 1'b1;
                        row_amb[c]  = 1'b0;
                    end else if (bl_rd[r][c] < VTH && blb_rd[r][c] >= VTH) begin
                        row_bits[c] = 1'b0;
                        row_amb[c]  = 1'b0;
                    end else begin
                        row_bits[c] = 1'b0;
                        row_amb[c]  = 1'b1;
                    end
                end
            end
        end
        one_hot     = (sel_count == 1);
        cap_dout    = one_hot ? row_bits : '0;
        cap_err_row = !one_hot;
        cap_err_bit = one_hot && (|row_amb);
    end

`ifdef SA_MARGIN_CHK_EN
    logic [COLS-1:0] row_weak;
    logic            cap_err_margin;

    always_comb begin
        row_weak = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_rd[r] >= VTH) begin
                for (int c = 0; c < COLS; c++) begin
                    row_weak[c] = ((bl_rd[r][c] - blb_rd[r][c]) < VMARGIN) &&
                                  ((blb_rd[r][c] - bl_rd[r][c]) < VMARGIN);
                end
            end
        end
        cap_err_margin = one_hot && (|row_weak);
    end
`else
    assign err_margin = 1'b0;
`endif

    // Sequencer and all registered outputs; captured results persist until
    // the next SENSE so a slow consumer always sees a stable word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pre_en     <= 1'b0;
            sa_en      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err_row    <= 1'b0;
            err_bit    <= 1'b0;
`ifdef SA_MARGIN_CHK_EN
            err_margin <= 1'b0;
`endif
            for (int c = 0; c < COLS; c++) begin
                preout[c] <= VSS;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state  <= PRECH;
                        cnt    <= 4'(PRE_CYC - 1);
                        pre_en <= 1'b1;
                    end
                end
                PRECH: begin
                    if (cnt == 4'd0) begin
                        state  <= DEVELOP;
                        cnt    <= 4'(DEV_CYC - 1);
                        pre_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DEVELOP: begin
                    if (cnt == 4'd0) begin
                        state <= SENSE;
                        sa_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SENSE: begin
                    state      <= DONE;
                    sa_en      <= 1'b0;
                    dout_valid <= 1'b1;
                    dout       <= cap_dout;
                    err_row    <= cap_err_row;
                    err_bit    <= cap_err_bit;
`ifdef SA_MARGIN_CHK_EN
                    err_margin <= cap_err_margin;
`endif
                    for (int c = 0; c < COLS; c++) begin
                        preout[c] <= cap_dout[c] ? VDD : VSS;
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        state      <= IDLE;
                        dout_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sense_amp_seq.sv
// Self-checking bench for sense_amp_seq: directed vector table, random reads
// against a rule-level model, and hand-written hold/reset sequences.
module tb_sense_amp_seq;

    localparam int ROWS    = 16;
    localparam int COLS    = 8;
    localparam int PRE_CYC = 2;
    localparam int DEV_CYC = 3;
    localparam int LATENCY = PRE_CYC + DEV_CYC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic        dout_ready = 1'b0;
    logic        rd_busy, pre_en, sa_en, dout_valid;
    logic        err_row, err_bit, err_margin;
    logic [7:0]  dout;
    real         row_rd [ROWS];
    real         bl_rd  [ROWS][COLS];
    real         blb_rd [ROWS][COLS];
    real         preout [COLS];

    int vec_count   = 0;
    int miscompares = 0;

    typedef struct {
        int         row_a;
        int         row_b;
        real        level;
        logic [7:0] data;
        int         amb_col;
        int         weak_col;
        logic [7:0] exp_dout;
        logic       exp_err_row;
        logic       exp_err_bit;
        logic       exp_weak;
    } vec_t;

    vec_t vecs [8];

    sense_amp_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .rd_busy    (rd_busy),
        .row_rd     (row_rd),
        .bl_rd      (bl_rd),
        .blb_rd     (blb_rd),
        .pre_en     (pre_en),
        .sa_en      (sa_en),
        .dout       (dout),
        .preout     (preout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_row    (err_row),
        .err_bit    (err_bit),
        .err_margin (err_margin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_preout(input string name, input logic [7:0] bits);
        int bad = 0;
        for (int c = 0; c < COLS; c++) begin
            if (preout[c] != (bits[c] ? 1.5 : 0.0)) bad++;
        end
        vec_count++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL %s: %0d preout columns differ from levels of %0h", name, bad, bits);
        end
    endtask

    // Fill the array: unselected rows carry random clean data so a wrong row
    // choice shows up in dout.
    task automatic apply_stimulus(input int row_a, input int row_b, input real level,
                                  input logic [7:0] data, input int amb_col, input int weak_col);
        for (int r = 0; r < ROWS; r++) begin
            row_rd[r] = 0.0;
            for (int c = 0; c < COLS; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    bl_rd[r][c] = 1.5; blb_rd[r][c] = 0.0;
                end else begin
                    bl_rd[r][c] = 0.0; blb_rd[r][c] = 1.5;
                end
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (r == row_a || r == row_b) begin
                row_rd[r] = level;
                for (int c = 0; c < COLS; c++) begin
                    bl_rd[r][c]  = data[c] ? 1.5 : 0.0;
                    blb_rd[r][c] = data[c] ? 0.0 : 1.5;
                    if (c == amb_col) begin
                        bl_rd[r][c] = 1.0; blb_rd[r][c] = 1.0;
                    end
                    if (c == weak_col) begin
                        bl_rd[r][c] = 0.9; blb_rd[r][c] = 0.75;
                    end
                end
            end
        end
    endtask

    // Reference: read the rules straight off the analog levels.
    task automatic model(output logic [7:0] d, output logic er, output logic eb, output logic em);
        int  sel [$];
        real diff;
        d = '0; er = 1'b1; eb = 1'b0; em = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_rd[r] >= 0.8) sel.push_back(r);
        end
        if (sel.size() == 1) begin
            er = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                if (bl_rd[sel[0]][c] >= 0.8 && blb_rd[sel[0]][c] < 0.8) d[c] = 1'b1;
                else if (!(bl_rd[sel[0]][c] < 0.8 && blb_rd[sel[0]][c] >= 0.8)) eb = 1'b1;
                diff = bl_rd[sel[0]][c] - blb_rd[sel[0]][c];
                if (diff < 0.0) diff = -diff;
`ifdef SA_MARGIN_CHK_EN
                if (diff < 0.2) em = 1'b1;
`endif
            end
        end
    endtask

    // Pulse rd_req into an idle DUT and count edges until dout_valid.
    task automatic do_read(output int latency, output int pre_cycles, output int sa_cycles);
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        latency    = 0;
        pre_cycles = int'(pre_en);
        sa_cycles  = int'(sa_en);
        while (!dout_valid && latency < 30) begin
            @(posedge clk);
            #1;
            latency++;
            pre_cycles += int'(pre_en);
            sa_cycles  += int'(sa_en);
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] ed, input logic er,
                                input logic eb, input logic em);
        check({name, " dout"}, 32'(dout), 32'(ed));
        check({name, " err_row"}, 32'(err_row), 32'(er));
        check({name, " err_bit"}, 32'(err_bit), 32'(eb));
        check({name, " err_margin"}, 32'(err_margin), 32'(em));
        check({name, " dout_valid"}, 32'(dout_valid), 32'd1);
        check_preout({name, " preout"}, ed);
    endtask

    task automatic release_done(input string name);
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
        check({name, " valid drop"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        int         lat, pre_n, sa_n, valid_seen;
        logic [7:0] md;
        logic       mer, meb, mem, exp_em;
        real        pal [7];

        pal = '{0.0, 0.5, 0.75, 0.8, 0.9, 1.0, 1.5};
        //          row_a row_b level data  amb weak  dout  erow ebit weak
        vecs[0] = '{5,   -1,  1.5,  8'hFF, -1, -1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2,    7,  1.2,  8'hFF, -1, -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4,   -1,  1.5,  8'hFF,  3, -1, 8'hF7, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{-1,  -1,  1.5,  8'hA5, -1, -1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0,   -1,  1.5,  8'h3C, -1,  0, 8'h3D, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{15,  -1,  1.5,  8'h81, -1, -1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{5,   -1,  0.8,  8'h5A, -1, -1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{9,   -1,  0.79, 8'h5A, -1, -1, 8'h00, 1'b1, 1'b0, 1'b0};

        apply_stimulus(-1, -1, 0.0, 8'h00, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_busy", 32'(rd_busy), 32'd0);
        check("reset pre_en", 32'(pre_en), 32'd0);
        check("reset dout_valid", 32'(dout_valid), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check_preout("reset preout", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].row_a, vecs[i].row_b, vecs[i].level, vecs[i].data,
                           vecs[i].amb_col, vecs[i].weak_col);
            do_read(lat, pre_n, sa_n);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(LATENCY));
            if (i == 0) begin
                check("vec0 pre_en cycles", 32'(pre_n), 32'(PRE_CYC));
                check("vec0 sa_en cycles", 32'(sa_n), 32'd1);
            end
`ifdef SA_MARGIN_CHK_EN
            exp_em = vecs[i].exp_weak;
`else
            exp_em = 1'b0;
`endif
            check_output($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_err_row,
                         vecs[i].exp_err_bit, exp_em);
            release_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            int mode, ra, rb;
            mode = int'($urandom_range(0, 9));
            ra   = (mode == 0) ? -1 : int'($urandom_range(0, ROWS - 1));
            rb   = (mode == 1) ? int'($urandom_range(0, ROWS - 1)) : -1;
            apply_stimulus(ra, rb, ($urandom_range(0, 1) == 1) ? 1.5 : 0.8, 8'($urandom),
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, COLS - 1)) : -1, -1);
            if (ra >= 0) begin
                for (int c = 0; c < COLS; c++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bl_rd[ra][c]  = pal[$urandom_range(0, 6)];
                        blb_rd[ra][c] = pal[$urandom_range(0, 6)];
                    end
                end
            end
            model(md, mer, meb, mem);
            do_read(lat, pre_n, sa_n);
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(LATENCY));
            check_output($sformatf("rnd%0d", i), md, mer, meb, mem);
            release_done($sformatf("rnd%0d", i));
        end

        // Slow consumer: word must hold while inputs change and rd_req is ignored.
        apply_stimulus(5, -1, 1.5, 8'hFF, -1, -1);
        do_read(lat, pre_n, sa_n);
        check("hold latency", 32'(lat), 32'(LATENCY));
        apply_stimulus(-1, -1, 0.0, 8'h00, -1, -1);
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d dout_valid", k), 32'(dout_valid), 32'd1);
            check($sformatf("hold%0d dout", k), 32'(dout), 32'hFF);
        end
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        rd_req     = 1'b0;
        check("accept-cycle rd_busy", 32'(rd_busy), 32'd0);
        check("accept-cycle dout_valid", 32'(dout_valid), 32'd0);
        @(posedge clk);
        #1;
        check("post-accept rd_busy", 32'(rd_busy), 32'd0);
        check("idle dout held", 32'(dout), 32'hFF);

        // Reset in DEVELOP aborts the access.
        apply_stimulus(5, -1, 1.5, 8'hFF, -1, -1);
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("develop rd_busy", 32'(rd_busy), 32'd1);
        check("develop pre_en", 32'(pre_en), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort rd_busy", 32'(rd_busy), 32'd0);
        check("abort sa_en", 32'(sa_en), 32'd0);
        check("abort dout", 32'(dout), 32'd0);
        check("abort errors", 32'({err_row, err_bit, err_margin}), 32'd0);
        check_preout("abort preout", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            valid_seen += int'(dout_valid) + int'(rd_busy);
        end
        check("post-abort quiet", 32'(valid_seen), 32'd0);
        do_read(lat, pre_n, sa_n);
        check("post-abort latency", 32'(lat), 32'(LATENCY));
        check_output("post-abort", 8'hFF, 1'b0, 1'b0, 1'b0);
        release_done("post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/sense_amp_seq.md
SENSE_AMP_SEQ -- requirements
Module: sense_amp_seq

Interface
REQ-001 Parameter ROWS, default 16, number of array rows (one-hot row select width).
REQ-002 Parameter COLS, default 8, number of bit columns sensed per access.
REQ-003 Parameter PRE_CYC, default 2, precharge/equalise phase length in clocks (legal range 1..15).
REQ-004 Parameter DEV_CYC, default 3, bitline-develop phase length in clocks (legal range 1..15).
REQ-005 Parameter VTH (real), default 0.8, logic threshold in volts.
REQ-006 Parameter VDD (real), default 1.5, output high level; VSS (real), default 0.0, output low level.
REQ-007 Parameter VMARGIN (real), default 0.2, minimum valid |BL-BLB| differential in volts.
REQ-008 Reset: one clock; reset asynchronous, active-low.
REQ-009 clk  input  1  system clock.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 rd_req  input  1  read request, sampled in IDLE only.
REQ-012 rd_busy  output  1  high in every state except IDLE.
REQ-013 row_rd  input  real[ROWS]  row read-select levels.
REQ-014 bl_rd / blb_rd  input  real[ROWS][COLS]  true/complement bitline levels.
REQ-015 pre_en  output  1  precharge/equalise enable to the array.
REQ-016 sa_en  output  1  sense-amp fire strobe.
REQ-017 dout  output  COLS  latched read word.
REQ-018 preout  output  real[COLS]  dout mapped to VDD (1) or VSS (0).
REQ-019 dout_valid  output  1  dout/preout valid; held until dout_ready.
REQ-020 dout_ready  input  1  consumer accepts dout.
REQ-021 err_row  output  1  zero or multiple rows selected at sense.
REQ-022 err_bit  output  1  at least one column ambiguous at sense.
REQ-023 err_margin  output  1  at least one column below VMARGIN (macro-dependent).

Function
REQ-024 FSM states IDLE, PRECH, DEVELOP, SENSE, DONE; IDLE->PRECH on rd_req=1.
REQ-025 PRECH lasts exactly PRE_CYC clocks with pre_en=1; then DEVELOP.
REQ-026 DEVELOP lasts exactly DEV_CYC clocks, pre_en=0, sa_en=0; then SENSE.
REQ-027 SENSE lasts one clock with sa_en=1; at its end dout, preout and error flags are registered and FSM enters DONE.
REQ-028 dout_valid=1 in DONE only, first asserted PRE_CYC+DEV_CYC+1 rising edges after the accepting edge.
REQ-029 DONE with dout_ready=1 -> IDLE; rd_req in that same cycle is ignored, accepted no earlier than the next cycle in IDLE.
REQ-030 dout, preout and error flags hold their values from the SENSE capture until the next SENSE capture.
REQ-031 Row is selected when row_rd >= VTH; exactly one selected row -> err_row=0, data taken from that row.
REQ-032 Zero or more than one selected row -> err_row=1, dout=0, err_bit=0, err_margin=0.
REQ-033 Per column: bl>=VTH and blb<VTH -> 1; bl<VTH and blb>=VTH -> 0; otherwise bit=0 and err_bit=1.
REQ-034 preout[c] is VDD when dout[c]=1, else VSS; no X/Z ever driven on dout.
REQ-035 rd_req while rd_busy=1 is ignored (no queueing).

Reset
REQ-036 rst_n=0 asynchronously forces IDLE, pre_en=0, sa_en=0, dout=0, preout=VSS, dout_valid=0, all error flags 0.
REQ-037 Reset mid-access aborts the access; after release no dout_valid until a new rd_req is accepted.

Configuration
REQ-038 Macro SA_MARGIN_CHK_EN defined: err_margin=1 at SENSE capture if any column of the selected row has |bl-blb| < VMARGIN; the data bit is still resolved per REQ-033.
REQ-039 SA_MARGIN_CHK_EN undefined: err_margin tied 0, no margin logic present.

Verification (PRE_CYC=2, DEV_CYC=3)
REQ-040 Row 5 only at 1.5, row 5 bl=1.5/blb=0.0 on all cols, rd_req pulse -> pre_en 2 cycles, sa_en 1 cycle, dout_valid 6 edges after accept, dout=8'hFF, preout all 1.5.
REQ-041 dout_ready held 0 for 4 cycles in DONE -> dout_valid and dout stable 4 cycles; rd_req during that window ignored.
REQ-042 Rows 2 and 7 both at 1.2 -> err_row=1, dout=8'h00.
REQ-043 Column 3 bl=blb=1.0 on selected row -> dout[3]=0, err_bit=1, other columns correct.
REQ-044 SA_MARGIN_CHK_EN defined, column 0 bl=0.9/blb=0.75 -> dout[0]=1, err_margin=1; macro undefined -> err_margin=0.
REQ-045 rst_n low during DEVELOP -> outputs to reset values immediately; no dout_valid until next request.
